// File: rtl/mult_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_arbiter_if
// Brief    : Requester-side and multiply-unit-side signal bundle for
//            mult_arbiter. Operand width follows `DATAWIDTH (parameters.vh);
//            when the build does not define it, 8 is used.
// Revision : 1.0  initial release
// ============================================================================
`ifndef DATAWIDTH
`define DATAWIDTH 8
`endif

interface mult_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]                req;
    logic [NREQ*(`DATAWIDTH+1)-1:0] a_in;
    logic [NREQ*(`DATAWIDTH+1)-1:0] b_in;
    logic [NREQ-1:0]                grant;
    logic [NREQ-1:0]                done;
    logic [2*`DATAWIDTH-1:0]        result;
    logic                           busy;
    logic                           mul_enable;
    logic [`DATAWIDTH:0]            mul_multiplicand;
    logic [`DATAWIDTH:0]            mul_multiplier;
    logic [2*`DATAWIDTH-1:0]        mul_product;
    logic                           mul_ready;

    // Arbiter side
    modport slave (
        input  req, a_in, b_in, mul_product, mul_ready,
        output grant, done, result, busy, mul_enable, mul_multiplicand, mul_multiplier
    );

    // Requester / multiply-unit environment side
    modport master (
        output req, a_in, b_in, mul_product, mul_ready,
        input  grant, done, result, busy, mul_enable, mul_multiplicand, mul_multiplier
    );
endinterface

`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_arbiter
// Brief    : Shares one multi-cycle multiply unit among NREQ (=4) requesters.
//            Round-robin by default; define MULT_ARB_FIXED_PRIO_EN for fixed
//            priority (lowest index wins). Width from `DATAWIDTH (default 8).
// Revision : 1.0  initial release
// ============================================================================
`ifndef DATAWIDTH
`define DATAWIDTH 8
`endif

module mult_arbiter #(
    parameter int NREQ = 4
) (
    input  logic          clk,
    input  logic          rst,
    mult_arbiter_if.slave bus
);
    localparam int c_opw       = `DATAWIDTH + 1;
    localparam int c_pw        = 2 * `DATAWIDTH;
    localparam int c_drain_max = 2 * `DATAWIDTH + 4;
    localparam int c_cntw      = $clog2(c_drain_max + 1);
    localparam int c_idxw      = $clog2(NREQ);

    localparam logic [2:0] c_s_drain = 3'd0;
    localparam logic [2:0] c_s_idle  = 3'd1;
    localparam logic [2:0] c_s_issue = 3'd2;
    localparam logic [2:0] c_s_guard = 3'd3;
    localparam logic [2:0] c_s_wait  = 3'd4;
    localparam logic [2:0] c_s_done  = 3'd5;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [c_cntw-1:0] r_cnt;
    logic [c_opw-1:0]  r_opa;
    logic [c_opw-1:0]  r_opb;
    logic [c_idxw-1:0] r_winner;
    logic [c_pw-1:0]   r_result;
    logic [c_idxw-1:0] w_win;
    logic              w_any;
    logic              w_take;
    logic [NREQ-1:0]   w_grant;
    logic [NREQ-1:0]   w_done;
    logic              w_busy;
    logic              w_en;

    assign w_take = (r_state == c_s_idle) && w_any;

`ifdef MULT_ARB_FIXED_PRIO_EN
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                w_win = c_idxw'(i);
                w_any = 1'b1;
            end
        end
    end
`else
    logic [c_idxw-1:0] r_last;

    always_ff @(posedge clk) begin
        if (rst)
            r_last <= c_idxw'(NREQ - 1);
        else if (w_take)
            r_last <= w_win;
    end

    // Scan from the farthest slot back towards last+1 so the nearest one wins.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req[c_idxw'(int'(r_last) + k)]) begin
                w_win = c_idxw'(int'(r_last) + k);
                w_any = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= c_s_drain;
        else
            r_state <= w_next;
    end

    // GUARD exists because mul_ready is still high from the previous product.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_s_drain: if (bus.mul_ready || (r_cnt == c_cntw'(c_drain_max))) w_next = c_s_idle;
            c_s_idle:  if (w_any) w_next = c_s_issue;
            c_s_issue: w_next = c_s_guard;
            c_s_guard: w_next = c_s_wait;
            c_s_wait:  if (bus.mul_ready) w_next = c_s_done;
            c_s_done:  w_next = c_s_idle;
            default:   w_next = c_s_drain;
        endcase
    end

    always_comb begin
        w_grant = '0;
        w_done  = '0;
        w_en    = 1'b0;
        w_busy  = 1'b1;
        if (!rst) begin
            case (r_state)
                c_s_idle: begin
                    w_busy = 1'b0;
                    if (w_any) w_grant[w_win] = 1'b1;
                end
                c_s_issue: w_en = 1'b1;
                c_s_done:  w_done[r_winner] = 1'b1;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_winner <= '0;
            r_result <= '0;
        end else begin
            if (r_state == c_s_drain)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
            if (w_take) begin
                r_opa    <= bus.a_in[int'(w_win)*c_opw +: c_opw];
                r_opb    <= bus.b_in[int'(w_win)*c_opw +: c_opw];
                r_winner <= w_win;
            end
            if ((r_state == c_s_wait) && bus.mul_ready)
                r_result <= bus.mul_product;
        end
    end

    assign bus.grant            = w_grant;
    assign bus.done             = w_done;
    assign bus.busy             = w_busy;
    assign bus.mul_enable       = w_en;
    assign bus.result           = r_result;
    assign bus.mul_multiplicand = r_opa;
    assign bus.mul_multiplier   = r_opb;
endmodule

`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_arbiter
// Brief    : Self-checking bench for mult_arbiter with a multiply-unit model
//            and a transaction-level arbitration/result scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`ifndef DATAWIDTH
`define DATAWIDTH 8
`endif

module tb_mult_arbiter;
    localparam int DW        = `DATAWIDTH;
    localparam int OPW       = DW + 1;
    localparam int PW        = 2 * DW;
    localparam int DRAIN_MAX = 2 * DW + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_arbiter_if #(.NREQ(4)) bus ();
    mult_arbiter #(.NREQ(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_mult(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[PW-1:0];
    endfunction

    function automatic int mu_lat(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        return (a == 0 || a == 1 || b == 0 || b == 1) ? 1 : 6;
    endfunction

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] v;
        v = '0;
        if (i >= 0 && i < 4) v[i] = 1'b1;
        return v;
    endfunction

    function automatic int pick(input logic [3:0] r, input int lw);
`ifdef MULT_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) if (r[i]) return i;
        if (lw < 0) return -1;
`else
        for (int k = 1; k <= 4; k++) if (r[(lw + k) % 4]) return (lw + k) % 4;
`endif
        return -1;
    endfunction

    // Multiply-unit model: no reset, starts one cycle after mul_enable, and
    // keeps a stale ready/product until then.
    logic          mu_en_d     = 1'b0;
    int            mu_cnt      = 0;
    logic [PW-1:0] mu_prod     = '0;
    logic          mu_hold_low = 1'b1;
    always @(posedge clk) begin
        mu_en_d <= bus.mul_enable;
        if (mu_en_d) begin
            mu_cnt  <= mu_lat(bus.mul_multiplicand, bus.mul_multiplier);
            mu_prod <= ref_mult(bus.mul_multiplicand, bus.mul_multiplier);
        end else if (mu_cnt > 0) begin
            mu_cnt <= mu_cnt - 1;
        end
    end
    assign bus.mul_ready   = (mu_cnt == 0) && !mu_hold_low;
    assign bus.mul_product = mu_prod;

    // Scoreboard: arbitration model plus the expected product of the op in flight.
    int            lw_m = 3;
    bit            outstanding = 1'b0;
    int            exp_idx = 0;
    logic [PW-1:0] exp_res = '0;
    int            n_grant[4] = '{0, 0, 0, 0};
    int            n_done[4]  = '{0, 0, 0, 0};
    int            n_grant_tot = 0;
    int            n_done_tot  = 0;

    always @(negedge clk) begin
        int w;
        if (rst) begin
            lw_m        = 3;
            outstanding = 1'b0;
        end else begin
            if (bus.grant != 0 || bus.done != 0)
                chk("grant_done_exclusive", {63'd0, (bus.grant != 0 && bus.done != 0)}, 64'd0);
            if (bus.grant != 0) begin
                w = pick(bus.req, lw_m);
                chk("arb_winner", bus.grant, onehot(w));
                chk("single_in_flight", outstanding, 0);
                if (w >= 0) begin
                    outstanding = 1'b1;
                    exp_idx     = w;
                    exp_res     = ref_mult(bus.a_in[w*OPW +: OPW], bus.b_in[w*OPW +: OPW]);
                    lw_m        = w;
                    n_grant[w]++;
                end
                n_grant_tot++;
            end
            if (bus.done != 0) begin
                chk("done_has_op", outstanding, 1);
                chk("done_idx", bus.done, onehot(exp_idx));
                chk("done_result", bus.result, exp_res);
                if (outstanding) n_done[exp_idx]++;
                outstanding = 1'b0;
                n_done_tot++;
            end
        end
    end

    task automatic randomize_ops();
        for (int i = 0; i < 4; i++) begin
            int sel;
            sel = $urandom_range(0, 7);
            bus.a_in[i*OPW +: OPW] = (sel == 0) ? '0 : (sel == 1) ? OPW'(1) : OPW'($urandom);
            sel = $urandom_range(0, 7);
            bus.b_in[i*OPW +: OPW] = (sel == 0) ? '0 : (sel == 1) ? OPW'(1) : OPW'($urandom);
        end
    endtask

    task automatic wait_grant(output logic [3:0] g);
        int cyc;
        g = '0;
        cyc = 0;
        while (g == 0 && cyc < 60) begin
            @(negedge clk);
            g = bus.grant;
            cyc++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (bus.busy && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, bus.busy, 0);
    endtask

    task automatic run_op(input int idx, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                          input logic [PW-1:0] exp, input int exp_lat, input string tag);
        logic [3:0] g;
        logic [3:0] d;
        int lat;
        @(posedge clk); #1;
        randomize_ops();
        bus.a_in[idx*OPW +: OPW] = a;
        bus.b_in[idx*OPW +: OPW] = b;
        bus.req[idx] = 1'b1;
        wait_grant(g);
        chk({tag, "_grant"}, g, onehot(idx));
        @(posedge clk); #1;
        bus.req[idx] = 1'b0;
        randomize_ops();
        d = '0;
        lat = 0;
        while (d == 0 && lat < 100) begin
            @(negedge clk);
            d = bus.done;
            lat++;
        end
        chk({tag, "_done"}, d, onehot(idx));
        chk({tag, "_result"}, bus.result, exp);
        chk({tag, "_latency"}, lat, exp_lat);
        repeat (3) @(negedge clk);
        chk({tag, "_held"}, bus.result, exp);
    endtask

    initial begin
        logic [3:0] g;
        int dc, cyc, gidx, lw, g1, d1, d0;
        bit saw;
        int exp_seq[5];

        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        rst = 1'b1;
        mu_hold_low = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", bus.grant, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 1);
        chk("rst_mul_enable", bus.mul_enable, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_multiplicand", bus.mul_multiplicand, 0);
        chk("rst_multiplier", bus.mul_multiplier, 0);

        // Drain with the multiply unit never ready: full count, no grants.
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req = 4'b0100;
        dc = 0;
        saw = 1'b0;
        @(negedge clk);
        while (bus.busy && dc < 100) begin
            if (bus.grant != 0) saw = 1'b1;
            dc++;
            @(negedge clk);
        end
        chk("drain_len", dc, DRAIN_MAX + 1);
        chk("drain_no_grant", saw, 0);
        chk("drain_exit_grant", bus.grant, 4'b0100);
        mu_hold_low = 1'b0;
        @(posedge clk); #1;
        bus.req = '0;
        wait_idle("drain_op_idle");

        run_op(0, 9'd5,    9'd7,    16'h0023, 10, "op_5x7");
        run_op(2, 9'h1FD,  9'd4,    16'hFFF4, 10, "op_m3x4");
        run_op(1, 9'd1,    9'h0B5,  16'h00B5, 5,  "op_1xB5");

        // All four requesting continuously after reset.
        @(posedge clk); #1;
        rst = 1'b1;
        randomize_ops();
        bus.req = 4'b1111;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        lw = 3;
        for (int i = 0; i < 5; i++) begin
            exp_seq[i] = pick(4'b1111, lw);
            lw = exp_seq[i];
        end
        for (int i = 0; i < 5; i++) begin
            wait_grant(g);
            gidx = -1;
            for (int j = 0; j < 4; j++) if (g == onehot(j)) gidx = j;
            chk($sformatf("rr_seq_%0d", i), gidx, exp_seq[i]);
        end
        @(posedge clk); #1;
        bus.req = '0;
        wait_idle("rr_idle");

        // Reset while waiting on the multiply unit: no done for that op.
        @(posedge clk); #1;
        bus.a_in[2*OPW +: OPW] = 9'h033;
        bus.b_in[2*OPW +: OPW] = 9'h011;
        bus.req[2] = 1'b1;
        wait_grant(g);
        chk("abort_grant", g, 4'b0100);
        @(posedge clk); #1;
        bus.req = '0;
        repeat (4) @(negedge clk);
        d0 = n_done_tot;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_done", bus.done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_idle("abort_drain_idle");
        chk("abort_no_done", n_done_tot - d0, 0);
        run_op(3, 9'd12, 9'd12, 16'h0090, 10, "op_12x12");

        // One-cycle request pulse while busy is withdrawn.
        @(posedge clk); #1;
        bus.a_in[0 +: OPW] = 9'h027;
        bus.b_in[0 +: OPW] = 9'h003;
        bus.req[0] = 1'b1;
        wait_grant(g);
        chk("pulse_grant0", g, 4'b0001);
        g1 = n_grant[1];
        d1 = n_done[1];
        @(posedge clk); #1;
        bus.req = '0;
        @(posedge clk); #1;
        bus.req[1] = 1'b1;
        @(posedge clk); #1;
        bus.req[1] = 1'b0;
        cyc = 0;
        g = '0;
        while (g == 0 && cyc < 60) begin
            @(negedge clk);
            g = bus.done;
            cyc++;
        end
        chk("pulse_done0", g, 4'b0001);
        repeat (10) @(negedge clk);
        chk("pulse_no_grant1", n_grant[1] - g1, 0);
        chk("pulse_no_done1", n_done[1] - d1, 0);

        // Random request masks with operands changing every cycle.
        for (int r = 0; r < 15; r++) begin
            logic [3:0] pend;
            pend = 4'($urandom_range(1, 15));
            cyc = 0;
            while (pend != 0 && cyc < 400) begin
                @(posedge clk); #1;
                randomize_ops();
                bus.req = pend;
                @(negedge clk);
                pend = pend & ~bus.grant;
                cyc++;
            end
            @(posedge clk); #1;
            bus.req = '0;
            chk("rand_all_granted", pend, 0);
            wait_idle("rand_idle");
        end

        chk("grants_minus_dones", n_grant_tot - n_done_tot, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish by time limit, required finish");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter: NREQ, 4, number of requesters sharing one multiply unit; only value 4 is supported.
REQ-002 SHALL take operand width from `DATAWIDTH in parameters.vh: operands are `DATAWIDTH+1 bits, two's complement; products are 2*`DATAWIDTH bits.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req  in  4  per-requester request level.
REQ-006 a_in  in  4*(`DATAWIDTH+1)  multiplicands; slice i belongs to requester i.
REQ-007 b_in  in  4*(`DATAWIDTH+1)  multipliers; slice i belongs to requester i.
REQ-008 grant  out  4  one-hot, one-cycle pulse: operands of requester i are captured.
REQ-009 done  out  4  one-hot, one-cycle pulse: result is valid for requester i.
REQ-010 result  out  2*`DATAWIDTH  last product; held until the next done pulse.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 mul_enable, mul_multiplicand, mul_multiplier  out  1, `DATAWIDTH+1, `DATAWIDTH+1  drive multiply unit.
REQ-013 mul_product, mul_ready  in  2*`DATAWIDTH, 1  returned from multiply unit.

Function
REQ-014 SHALL implement states DRAIN, IDLE, ISSUE, GUARD, WAIT, DONE.
REQ-015 DRAIN: a counter SHALL run from 0; exit to IDLE when mul_ready=1 or the counter reaches 2*`DATAWIDTH+4; no grants are issued while in DRAIN.
REQ-016 IDLE: if any req bit is set, grant the winner (REQ-022) that cycle, latch its a/b slices into operand registers, latch the winner index, and go to ISSUE; otherwise stay in IDLE.
REQ-017 ISSUE: mul_enable=1 for exactly this one cycle with latched operands; next state GUARD.
REQ-018 GUARD: one cycle; mul_ready SHALL be ignored because it is stale from the previous operation; next state WAIT.
REQ-019 WAIT: on mul_ready=1, latch mul_product into result and go to DONE; otherwise stay in WAIT, with no timeout.
REQ-020 DONE: done[winner]=1 for one cycle; next state IDLE. Operand registers SHALL drive mul_multiplicand/mul_multiplier continuously from ISSUE through DONE.
REQ-021 Latency: grant to done = 4 + multiply-unit cycles; skip cases (operand 0/1) complete in minimum time.
REQ-022 Arbitration SHALL be round-robin: search starts at (last_winner+1) mod 4; last_winner updates at grant.
REQ-023 A req that drops before grant SHALL be treated as withdrawn, with no operation and no done.
REQ-024 A req held through and after done SHALL be re-arbitrated in IDLE as a new request; round-robin order guarantees other pending requesters are served first.
REQ-025 req, a_in and b_in changes after grant SHALL NOT affect the operation in flight.
REQ-026 grant and done SHALL never both be asserted in the same cycle; at most one operation is in flight.

Reset
REQ-027 rst=1 SHALL force state to DRAIN, clear the drain counter, set last_winner=3, and drive grant=0, done=0, result=0, busy=1, mul_enable=0, and operand registers=0.
REQ-028 rst mid-operation SHALL abort it with no done; the multiply unit has no reset, so DRAIN absorbs its remaining run.

Configuration
REQ-029 Macro MULT_ARB_FIXED_PRIO_EN: when defined, arbitration SHALL be fixed priority (lowest index wins) and last_winner is not used; when undefined, it is round-robin per REQ-022.

Verification
REQ-030 With `DATAWIDTH=8: rst, then req[0] with a=5, b=7 -> grant[0] pulse, then done[0] with result=16'h0023.
REQ-031 req[2] with a=9'h1FD (-3), b=4 -> done[2] with result=16'hFFF4.
REQ-032 req=4'b1111 held continuously after reset -> grants in order 0,1,2,3,0 (round-robin); with MULT_ARB_FIXED_PRIO_EN -> grants 0,0,0.
REQ-033 req[1] with a=1, b=9'h0B5 -> done[1] with result=16'h00B5; WAIT is not exited on stale mul_ready.
REQ-034 rst asserted during WAIT -> no done pulse; after DRAIN, req[3] with a=12, b=12 -> done[3] with result=16'h0090.
REQ-035 req[1] pulsed for one cycle while an operation is in flight -> no grant[1] and no done[1].
